// File: rtl/cadence_pkg.sv
// Shared types and sizing constants for the cadence sequencing controller.
package cadence_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARM   = 2'd1,
    PEDAL = 2'd2
  } state_t;

  localparam int PRESC_FAST = 4;
  localparam int PRESC_SLOW = 12;
  localparam int PERIOD_W   = 16;
  localparam int AVG_DEPTH  = 4;

endpackage

// File: rtl/period_avg4.sv
// Four-entry period history with a running sum; average and valid are
// registered one stage behind the push.
module period_avg4
  import cadence_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                push,
  input  logic                clr,
  input  logic [PERIOD_W-1:0] din,
  output logic [PERIOD_W-1:0] period_avg,
  output logic                avg_vld
);

  localparam int SUM_W  = PERIOD_W + 2;
  localparam int FILL_W = $clog2(AVG_DEPTH + 1);

  logic [PERIOD_W-1:0] hist_p0 [AVG_DEPTH];
  logic [SUM_W-1:0]    sum_p0;
  logic [FILL_W-1:0]   fill_p0;

  // Stage 0: shift history and keep sum = sum + new - oldest.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      for (int i = 0; i < AVG_DEPTH; i++) hist_p0[i] <= '0;
      sum_p0  <= '0;
      fill_p0 <= '0;
    end else if (push) begin
      for (int i = AVG_DEPTH - 1; i > 0; i--) hist_p0[i] <= hist_p0[i-1];
      hist_p0[0] <= din;
      sum_p0     <= sum_p0 + SUM_W'(din) - SUM_W'(hist_p0[AVG_DEPTH-1]);
      if (fill_p0 != FILL_W'(AVG_DEPTH)) fill_p0 <= fill_p0 + 1'b1;
    end
  end

  // Stage 1: truncating divide by four and fill qualification.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      period_avg <= '0;
      avg_vld    <= 1'b0;
    end else begin
      period_avg <= sum_p0[SUM_W-1:2];
      avg_vld    <= (fill_p0 == FILL_W'(AVG_DEPTH));
    end
  end

endmodule

// File: rtl/cadence_ctrl.sv
// Cadence sequencing controller: timestamps filtered cadence edges on a
// prescaled time base, measures periods and tracks pedaling state.
module cadence_ctrl
  import cadence_pkg::*;
#(
  parameter bit          FAST_SIM = 1'b0,
  parameter logic [15:0] TIMEOUT  = 16'd12000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                cadence_filt,
  output logic                cadence_rise,
  output logic [PERIOD_W-1:0] period,
  output logic                period_vld,
  output logic [PERIOD_W-1:0] period_avg,
  output logic                avg_vld,
  output logic                not_pedaling
);

  localparam int PW = FAST_SIM ? PRESC_FAST : PRESC_SLOW;

  function automatic logic [PERIOD_W-1:0] sat_inc(input logic [PERIOD_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic                prev_p0;
  logic [PW-1:0]       presc_p0;
  logic [PERIOD_W-1:0] cnt_p0;
  state_t              state, state_nxt;
  logic                rise_det, rise, tick, timeout, capture, hist_clr;

  assign rise_det = cadence_filt & ~prev_p0;
  assign rise     = rise_det & en;
  assign tick     = &presc_p0;
  assign timeout  = (cnt_p0 >= TIMEOUT);
  assign hist_clr = (state_nxt == IDLE);

  // Stage 0: edge history keeps sampling even while disabled.
  always_ff @(posedge clk) begin
    if (rst) prev_p0 <= 1'b0;
    else     prev_p0 <= cadence_filt;
  end

  always_ff @(posedge clk) begin
    if (rst || !en) begin
      presc_p0 <= '0;
      cnt_p0   <= '0;
    end else if (rise) begin
      presc_p0 <= '0;
      cnt_p0   <= '0;
    end else begin
      presc_p0 <= presc_p0 + 1'b1;
      if (tick) cnt_p0 <= sat_inc(cnt_p0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // An edge always wins over a same-cycle timeout.
  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    unique case (state)
      IDLE: if (rise) state_nxt = ARM;
      ARM: begin
        if (rise) begin
          state_nxt = PEDAL;
          capture   = 1'b1;
        end else if (timeout) begin
          state_nxt = IDLE;
        end
      end
      PEDAL: begin
        if (rise)         capture   = 1'b1;
        else if (timeout) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (!en) begin
      state_nxt = IDLE;
      capture   = 1'b0;
    end
  end

  // Stage 1: registered outputs; period captures the pre-tick count.
  always_ff @(posedge clk) begin
    if (rst) begin
      cadence_rise <= 1'b0;
      period_vld   <= 1'b0;
      not_pedaling <= 1'b1;
      period       <= '0;
    end else begin
      cadence_rise <= rise;
      period_vld   <= capture;
      not_pedaling <= (state_nxt != PEDAL);
      if (capture) period <= cnt_p0;
    end
  end

  period_avg4 u_avg (
    .clk        (clk),
    .rst        (rst),
    .push       (capture),
    .clr        (hist_clr),
    .din        (cnt_p0),
    .period_avg (period_avg),
    .avg_vld    (avg_vld)
  );

endmodule

// File: tb/tb_cadence_ctrl.sv
// Directed bench for cadence_ctrl with FAST_SIM=1 (1 tick = 16 clk).
module tb_cadence_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        cadence_filt;
  logic        cadence_rise;
  logic [15:0] period;
  logic        period_vld;
  logic [15:0] period_avg;
  logic        avg_vld;
  logic        not_pedaling;

  int checks = 0;
  int errors = 0;

  cadence_ctrl #(.FAST_SIM(1'b1), .TIMEOUT(16'd600)) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .cadence_filt (cadence_filt),
    .cadence_rise (cadence_rise),
    .period       (period),
    .period_vld   (period_vld),
    .period_avg   (period_avg),
    .avg_vld      (avg_vld),
    .not_pedaling (not_pedaling)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Edge sampled exactly gap clocks after the current edge; returns just after it.
  task automatic pulse(input int gap, input bit hold);
    if (gap > 1) repeat (gap - 1) @(posedge clk);
    #1 cadence_filt = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) cadence_filt = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; en = 1'b1; cadence_filt = 1'b0;
    step(100);
    checks++; if (period !== 16'd0) begin errors++; $display("FAIL reset_period: got %0d want 0", period); end
    checks++; if (period_vld !== 1'b0) begin errors++; $display("FAIL reset_period_vld: got %b want 0", period_vld); end
    checks++; if (period_avg !== 16'd0) begin errors++; $display("FAIL reset_avg: got %0d want 0", period_avg); end
    checks++; if (avg_vld !== 1'b0) begin errors++; $display("FAIL reset_avg_vld: got %b want 0", avg_vld); end
    checks++; if (cadence_rise !== 1'b0) begin errors++; $display("FAIL reset_rise: got %b want 0", cadence_rise); end
    checks++; if (not_pedaling !== 1'b1) begin errors++; $display("FAIL reset_not_pedaling: got %b want 1", not_pedaling); end
    rst = 1'b0;
  endtask

  task automatic test_first_edges;
    pulse(10, 1'b0);
    checks++; if (cadence_rise !== 1'b1) begin errors++; $display("FAIL first_rise: got %b want 1", cadence_rise); end
    checks++; if (period_vld !== 1'b0) begin errors++; $display("FAIL first_no_period: got %b want 0", period_vld); end
    checks++; if (not_pedaling !== 1'b1) begin errors++; $display("FAIL first_arm: got %b want 1", not_pedaling); end
    step(1);
    checks++; if (cadence_rise !== 1'b0) begin errors++; $display("FAIL rise_one_cycle: got %b want 0", cadence_rise); end
    for (int i = 2; i <= 5; i++) begin
      pulse(1607, 1'b0);
      checks++; if (period !== 16'd100) begin errors++; $display("FAIL edge%0d_period: got %0d want 100", i, period); end
      checks++; if (period_vld !== 1'b1) begin errors++; $display("FAIL edge%0d_vld: got %b want 1", i, period_vld); end
      checks++; if (not_pedaling !== 1'b0) begin errors++; $display("FAIL edge%0d_pedal: got %b want 0", i, not_pedaling); end
      checks++; if (avg_vld !== 1'b0) begin errors++; $display("FAIL edge%0d_avg_vld_early: got %b want 0", i, avg_vld); end
      step(1);
      checks++; if (period_vld !== 1'b0) begin errors++; $display("FAIL edge%0d_vld_pulse: got %b want 0", i, period_vld); end
      checks++; if (avg_vld !== (i == 5)) begin errors++; $display("FAIL edge%0d_avg_vld: got %b want %b", i, avg_vld, (i == 5)); end
    end
    checks++; if (period_avg !== 16'd100) begin errors++; $display("FAIL first_avg: got %0d want 100", period_avg); end
  endtask

  task automatic test_avg_seq;
    int p [5]   = '{100, 200, 300, 400, 500};
    int exp [5] = '{100, 125, 175, 250, 350};
    for (int i = 0; i < 5; i++) begin
      pulse(16 * p[i] + 7, 1'b0);
      checks++; if (period !== 16'(p[i])) begin errors++; $display("FAIL seq%0d_period: got %0d want %0d", i, period, p[i]); end
      step(1);
      checks++; if (period_avg !== 16'(exp[i])) begin errors++; $display("FAIL seq%0d_avg: got %0d want %0d", i, period_avg, exp[i]); end
    end
  endtask

  task automatic test_timeout;
    step(9599);
    checks++; if (not_pedaling !== 1'b0) begin errors++; $display("FAIL timeout_early: got %b want 0", not_pedaling); end
    checks++; if (avg_vld !== 1'b1) begin errors++; $display("FAIL timeout_early_avg_vld: got %b want 1", avg_vld); end
    step(1);
    checks++; if (not_pedaling !== 1'b1) begin errors++; $display("FAIL timeout_idle: got %b want 1", not_pedaling); end
    checks++; if (avg_vld !== 1'b0) begin errors++; $display("FAIL timeout_avg_vld: got %b want 0", avg_vld); end
    checks++; if (period_avg !== 16'd0) begin errors++; $display("FAIL timeout_avg: got %0d want 0", period_avg); end
    checks++; if (period !== 16'd500) begin errors++; $display("FAIL timeout_period_hold: got %0d want 500", period); end
  endtask

  task automatic test_enable;
    pulse(10, 1'b0);
    checks++; if (cadence_rise !== 1'b1) begin errors++; $display("FAIL en_arm_rise: got %b want 1", cadence_rise); end
    checks++; if (period_vld !== 1'b0) begin errors++; $display("FAIL en_arm_no_period: got %b want 0", period_vld); end
    pulse(1608, 1'b0);
    checks++; if (not_pedaling !== 1'b0) begin errors++; $display("FAIL en_pedal: got %b want 0", not_pedaling); end
    pulse(1608, 1'b1);
    checks++; if (period !== 16'd100) begin errors++; $display("FAIL en_hold_period: got %0d want 100", period); end
    step(3);
    en = 1'b0;
    step(1);
    checks++; if (not_pedaling !== 1'b1) begin errors++; $display("FAIL en_off_idle: got %b want 1", not_pedaling); end
    step(4);
    en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step(1);
      checks++; if (cadence_rise !== 1'b0) begin errors++; $display("FAIL en_on_rise%0d: got %b want 0", i, cadence_rise); end
      checks++; if (not_pedaling !== 1'b1) begin errors++; $display("FAIL en_on_idle%0d: got %b want 1", i, not_pedaling); end
    end
    cadence_filt = 1'b0;
    step(2);
    pulse(10, 1'b0);
    checks++; if (cadence_rise !== 1'b1) begin errors++; $display("FAIL en_rearm_rise: got %b want 1", cadence_rise); end
    checks++; if (period_vld !== 1'b0) begin errors++; $display("FAIL en_rearm_no_period: got %b want 0", period_vld); end
    checks++; if (not_pedaling !== 1'b1) begin errors++; $display("FAIL en_rearm_state: got %b want 1", not_pedaling); end
    pulse(808, 1'b0);
    checks++; if (period !== 16'd50) begin errors++; $display("FAIL en_repedal_period: got %0d want 50", period); end
    checks++; if (not_pedaling !== 1'b0) begin errors++; $display("FAIL en_repedal_state: got %b want 0", not_pedaling); end
  endtask

  task automatic test_boundaries;
    pulse(1600, 1'b0);
    checks++; if (period !== 16'd99) begin errors++; $display("FAIL tick_edge_period: got %0d want 99", period); end
    checks++; if (period_vld !== 1'b1) begin errors++; $display("FAIL tick_edge_vld: got %b want 1", period_vld); end
    pulse(9601, 1'b0);
    checks++; if (period !== 16'd600) begin errors++; $display("FAIL timeout_edge_period: got %0d want 600", period); end
    checks++; if (not_pedaling !== 1'b0) begin errors++; $display("FAIL timeout_edge_state: got %b want 0", not_pedaling); end
    checks++; if (cadence_rise !== 1'b1) begin errors++; $display("FAIL timeout_edge_rise: got %b want 1", cadence_rise); end
    pulse(1624, 1'b0);
    checks++; if (period !== 16'd101) begin errors++; $display("FAIL trunc_period: got %0d want 101", period); end
    step(1);
    checks++; if (period_avg !== 16'd212) begin errors++; $display("FAIL trunc_avg: got %0d want 212", period_avg); end
    checks++; if (avg_vld !== 1'b1) begin errors++; $display("FAIL trunc_avg_vld: got %b want 1", avg_vld); end
  endtask

  task automatic test_mid_reset;
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    checks++; if (period !== 16'd0) begin errors++; $display("FAIL midrst_period: got %0d want 0", period); end
    checks++; if (not_pedaling !== 1'b1) begin errors++; $display("FAIL midrst_state: got %b want 1", not_pedaling); end
    checks++; if (avg_vld !== 1'b0) begin errors++; $display("FAIL midrst_avg_vld: got %b want 0", avg_vld); end
  endtask

  initial begin
    test_reset();
    test_first_edges();
    test_avg_seq();
    test_timeout();
    test_enable();
    test_boundaries();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
